quad_step_decoder: RTL and testbench

//  Input-side companion of the LED up/down counter: reads a 2-channel quadrature
//  (rotary encoder) input, synchronises and debounces it, decodes direction and

---
 rtl/quad_step_decoder_pkg.sv | 39 +++
 rtl/quad_step_decoder_if.sv | 17 +
 rtl/quad_debounce.sv | 108 ++++++++++
 rtl/quad_step_decoder.sv | 92 +++++++++
 tb/tb_quad_step_decoder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/quad_step_decoder_pkg.sv
// Shared definitions for the quadrature step decoder: debounce FSM states,
// movement classes and the quadrature transition classifier.
package quad_step_decoder_pkg;

  // Debounce FSM: INIT learns the resting position, TRACK reports changes.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } deb_state_e;

  // Classification of one debounced {A,B} transition.
  typedef enum logic [1:0] {
    MOVE_NONE    = 2'd0,
    MOVE_UP      = 2'd1,
    MOVE_DOWN    = 2'd2,
    MOVE_ILLEGAL = 2'd3
  } move_e;

  // Quadrature positions, {A,B}.
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  // Up cycle is 00->01->11->10->00, down is the reverse; a jump of two
  // positions (both channels changed) cannot be attributed to a direction.
  function automatic move_e classify_move(input logic [1:0] old_ab,
                                          input logic [1:0] new_ab);
    move_e m;
    case ({old_ab, new_ab})
      {AB_00, AB_01}, {AB_01, AB_11}, {AB_11, AB_10}, {AB_10, AB_00}: m = MOVE_UP;
      {AB_00, AB_10}, {AB_10, AB_11}, {AB_11, AB_01}, {AB_01, AB_00}: m = MOVE_DOWN;
      {AB_00, AB_11}, {AB_11, AB_00}, {AB_01, AB_10}, {AB_10, AB_01}: m = MOVE_ILLEGAL;
      default: m = MOVE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder pins and decoded outputs of the quadrature step decoder.
// master = encoder/board side, slave = decoder.
interface quad_step_decoder_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 ENC_A;
  logic                 ENC_B;
  logic                 STEP;
  logic                 DIR;
  logic                 ERR;
  logic [CNT_WIDTH-1:0] COUNT;

  modport master (output ENC_A, output ENC_B,
                  input  STEP, input DIR, input ERR, input COUNT);
  modport slave  (input  ENC_A, input ENC_B,
                  output STEP, output DIR, output ERR, output COUNT);
endinterface

// File: rtl/quad_debounce.sv
// Two-flop synchroniser plus shared-counter pair debounce for the encoder
// channels. INIT silently adopts the resting position; TRACK raises a
// registered one-cycle upd with the previous debounced value in old_ab.
module quad_debounce
  import quad_step_decoder_pkg::*;
#(
  parameter int DEB_WIDTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [1:0] deb_ab,
  output logic       upd,
  output logic [1:0] old_ab
);

  localparam logic [DEB_WIDTH-1:0] DEB_MAX  = {DEB_WIDTH{1'b1}};
  localparam logic [DEB_WIDTH-1:0] DEB_ZERO = {DEB_WIDTH{1'b0}};
  localparam logic [DEB_WIDTH-1:0] DEB_ONE  = {{(DEB_WIDTH-1){1'b0}}, 1'b1};

  logic                 a_meta_r, a_sync_r, b_meta_r, b_sync_r;
  logic [1:0]           ab_s;
  deb_state_e           state_r, state_nxt_s;
  logic [1:0]           deb_r, deb_nxt_s;
  logic [1:0]           old_r, old_nxt_s;
  logic [DEB_WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic                 upd_r, upd_nxt_s;

  // Bring both asynchronous pins into the CLK domain, nothing between flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_meta_r <= 1'b0;
      a_sync_r <= 1'b0;
      b_meta_r <= 1'b0;
      b_sync_r <= 1'b0;
    end else begin
      a_meta_r <= enc_a;
      a_sync_r <= a_meta_r;
      b_meta_r <= enc_b;
      b_sync_r <= b_meta_r;
    end
  end

  assign ab_s = {a_sync_r, b_sync_r};

  // Debounce state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_INIT;
      deb_r   <= 2'b00;
      old_r   <= 2'b00;
      cnt_r   <= DEB_ZERO;
      upd_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      deb_r   <= deb_nxt_s;
      old_r   <= old_nxt_s;
      cnt_r   <= cnt_nxt_s;
      upd_r   <= upd_nxt_s;
    end
  end

  // Next-state logic: one counter measures how long the pair has differed.
  always_comb begin
    state_nxt_s = state_r;
    deb_nxt_s   = deb_r;
    old_nxt_s   = old_r;
    cnt_nxt_s   = cnt_r;
    upd_nxt_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        deb_nxt_s = ab_s;
        if (ab_s != deb_r) begin
          cnt_nxt_s = DEB_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + DEB_ONE;
        end
        if (cnt_r == DEB_MAX) begin
          state_nxt_s = ST_TRACK;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_TRACK: begin
        if (ab_s == deb_r) begin
          cnt_nxt_s = DEB_ZERO;
        end else if (cnt_r != DEB_MAX) begin
          cnt_nxt_s = cnt_r + DEB_ONE;
        end else begin
          deb_nxt_s = ab_s;
          old_nxt_s = deb_r;
          cnt_nxt_s = DEB_ZERO;
          upd_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = DEB_ZERO;
      end
    endcase
  end

  assign deb_ab = deb_r;
  assign old_ab = old_r;
  assign upd    = upd_r;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: debounced x4 decode into step/error pulses,
// a held direction flag and a wrapping step count shown active-low.
module quad_step_decoder
  import quad_step_decoder_pkg::*;
#(
  parameter int DEB_WIDTH = 16,
  parameter int CNT_WIDTH = 4
) (
  input logic                CLK,
  input logic                RESET,
  quad_step_decoder_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic [1:0]           deb_ab_s, old_ab_s;
  logic                 upd_s;
  move_e                move_s;
  logic                 step_r, step_nxt_s;
  logic                 err_r, err_nxt_s;
  logic                 dir_r, dir_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_WIDTH-1:0] count_r;

  quad_debounce #(
    .DEB_WIDTH(DEB_WIDTH)
  ) u_debounce (
    .CLK    (CLK),
    .RESET  (RESET),
    .enc_a  (bus.ENC_A),
    .enc_b  (bus.ENC_B),
    .deb_ab (deb_ab_s),
    .upd    (upd_s),
    .old_ab (old_ab_s)
  );

  // Classify the accepted transition and derive the next output values.
  always_comb begin
    move_s     = MOVE_NONE;
    step_nxt_s = 1'b0;
    err_nxt_s  = 1'b0;
    dir_nxt_s  = dir_r;
    cnt_nxt_s  = cnt_r;
    if (upd_s) begin
      move_s = classify_move(old_ab_s, deb_ab_s);
    end else begin
      move_s = MOVE_NONE;
    end
    case (move_s)
      MOVE_UP: begin
        step_nxt_s = 1'b1;
        dir_nxt_s  = 1'b1;
        cnt_nxt_s  = cnt_r + CNT_ONE;
      end
      MOVE_DOWN: begin
        step_nxt_s = 1'b1;
        dir_nxt_s  = 1'b0;
        cnt_nxt_s  = cnt_r - CNT_ONE;
      end
      MOVE_ILLEGAL: begin
        err_nxt_s = 1'b1;
      end
      default: begin
        step_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers; the LED-facing count is kept pre-inverted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      step_r  <= 1'b0;
      err_r   <= 1'b0;
      dir_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      count_r <= ~CNT_ZERO;
    end else begin
      step_r  <= step_nxt_s;
      err_r   <= err_nxt_s;
      dir_r   <= dir_nxt_s;
      cnt_r   <= cnt_nxt_s;
      count_r <= ~cnt_nxt_s;
    end
  end

  assign bus.STEP  = step_r;
  assign bus.ERR   = err_r;
  assign bus.DIR   = dir_r;
  assign bus.COUNT = count_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder with DEB_WIDTH=2 (DEB_MAX=3), CNT_WIDTH=4:
// directed transition table, glitch / reset corner cases, then random moves
// checked against a position-difference model.
module tb_quad_step_decoder;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_total = 0;
  int   err_total  = 0;

  quad_step_decoder_if #(.CNT_WIDTH(4)) bus ();

  quad_step_decoder #(
    .DEB_WIDTH(2),
    .CNT_WIDTH(4)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    bit         exp_step;
    bit         exp_err;
    bit         exp_dir;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.STEP) step_total++;
      if (bus.ERR)  err_total++;
      if (bus.STEP || bus.ERR)
        check("step_err_exclusive", !(bus.STEP && bus.ERR),
              {30'd0, bus.STEP, bus.ERR}, 32'd0);
    end
  end

  task automatic hold(input logic [1:0] ab, input int n);
    {bus.ENC_A, bus.ENC_B} = ab;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Change pins, watch 10 cycles; a pulse must appear exactly 7 cycles later.
  task automatic apply_vec(input vec_t v, input string name);
    int sp_n, sp_at, er_n, er_at;
    logic [3:0] exp_count;
    sp_n = 0; sp_at = 0; er_n = 0; er_at = 0;
    {bus.ENC_A, bus.ENC_B} = v.ab;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.STEP) begin sp_n++; sp_at = k; end
      if (bus.ERR)  begin er_n++; er_at = k; end
    end
    exp_count = ~4'(v.exp_cnt);
    check({name, "_step"}, v.exp_step ? (sp_n == 1 && sp_at == 7) : (sp_n == 0),
          sp_n * 100 + sp_at, v.exp_step ? 107 : 0);
    check({name, "_err"}, v.exp_err ? (er_n == 1 && er_at == 7) : (er_n == 0),
          er_n * 100 + er_at, v.exp_err ? 107 : 0);
    check({name, "_dir"}, bus.DIR == v.exp_dir, bus.DIR, v.exp_dir);
    check({name, "_count"}, bus.COUNT == exp_count, bus.COUNT, exp_count);
  endtask

  // Gray-code position of a quadrature state along the up direction.
  function automatic int pos(input logic [1:0] ab);
    int p;
    case (ab)
      2'b00: p = 0;
      2'b01: p = 1;
      2'b11: p = 2;
      default: p = 3;
    endcase
    return p;
  endfunction

  initial begin
    int s0, e0, m_cnt, diff, exp_steps, exp_errs;
    bit m_dir;
    logic [1:0] st, t, g;
    logic [3:0] exp_count;

    vecs[0]  = '{2'b01, 1'b1, 1'b0, 1'b1, 1};
    vecs[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2};
    vecs[2]  = '{2'b10, 1'b1, 1'b0, 1'b1, 3};
    vecs[3]  = '{2'b00, 1'b1, 1'b0, 1'b1, 4};
    vecs[4]  = '{2'b10, 1'b1, 1'b0, 1'b0, 3};
    vecs[5]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2};
    vecs[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{2'b00, 1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{2'b10, 1'b1, 1'b0, 1'b0, 15};
    vecs[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 14};
    vecs[10] = '{2'b01, 1'b1, 1'b0, 1'b0, 13};
    vecs[11] = '{2'b00, 1'b1, 1'b0, 1'b0, 12};
    vecs[12] = '{2'b11, 1'b0, 1'b1, 1'b0, 12};
    vecs[13] = '{2'b00, 1'b0, 1'b1, 1'b0, 12};
    vecs[14] = '{2'b01, 1'b1, 1'b0, 1'b1, 13};
    vecs[15] = '{2'b10, 1'b0, 1'b1, 1'b1, 13};
    vecs[16] = '{2'b11, 1'b1, 1'b0, 1'b0, 12};

    // Reset with AB=11 held: reset values, then INIT learns 11 silently.
    rst = 1'b1;
    bus.ENC_A = 1'b1;
    bus.ENC_B = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.COUNT == 4'b1111, bus.COUNT, 4'b1111);
    check("rst_step", bus.STEP == 1'b0, bus.STEP, 1'b0);
    check("rst_err", bus.ERR == 1'b0, bus.ERR, 1'b0);
    check("rst_dir", bus.DIR == 1'b0, bus.DIR, 1'b0);
    s0 = step_total; e0 = err_total;
    rst = 1'b0;
    hold(2'b11, 15);
    check("init_no_step", step_total == s0, step_total - s0, 0);
    check("init_no_err", err_total == e0, err_total - e0, 0);
    check("init_count", bus.COUNT == 4'b1111, bus.COUNT, 4'b1111);
    apply_vec('{2'b10, 1'b1, 1'b0, 1'b1, 1}, "init11_up");

    // Reset at 00, then walk the transition table.
    rst = 1'b1;
    hold(2'b00, 3);
    rst = 1'b0;
    hold(2'b00, 10);
    for (int i = 0; i < 17; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Glitch on A for 3 cycles from 11: no pulse, count held at 12.
    s0 = step_total; e0 = err_total;
    hold(2'b01, 3);
    hold(2'b11, 12);
    check("glitch_no_step", step_total == s0, step_total - s0, 0);
    check("glitch_no_err", err_total == e0, err_total - e0, 0);
    check("glitch_count", bus.COUNT == 4'b0011, bus.COUNT, 4'b0011);

    // Reset while the 11->10 change is part way through debounce.
    hold(2'b10, 4);
    rst = 1'b1;
    #1;
    check("midrst_count", bus.COUNT == 4'b1111, bus.COUNT, 4'b1111);
    check("midrst_step", bus.STEP == 1'b0, bus.STEP, 1'b0);
    check("midrst_dir", bus.DIR == 1'b0, bus.DIR, 1'b0);
    hold(2'b10, 2);
    s0 = step_total; e0 = err_total;
    rst = 1'b0;
    hold(2'b10, 15);
    check("midrst_no_step", step_total == s0, step_total - s0, 0);
    check("midrst_no_err", err_total == e0, err_total - e0, 0);
    check("midrst_count_held", bus.COUNT == 4'b1111, bus.COUNT, 4'b1111);
    apply_vec('{2'b00, 1'b1, 1'b0, 1'b1, 1}, "post_rst_up");

    // Random moves with optional short glitches against the position model.
    st = 2'b00; m_cnt = 1; m_dir = 1'b1;
    for (int op = 0; op < 40; op++) begin
      s0 = step_total; e0 = err_total;
      if ($urandom_range(1, 0) == 1) begin
        g = 2'($urandom_range(3, 0));
        if (g == st) g = st ^ 2'b10;
        hold(g, $urandom_range(3, 1));
        hold(st, $urandom_range(3, 1));
      end
      t = 2'($urandom_range(3, 0));
      hold(t, $urandom_range(12, 10));
      diff = (pos(t) - pos(st) + 4) % 4;
      exp_steps = 0; exp_errs = 0;
      if (diff == 1) begin
        exp_steps = 1; m_dir = 1'b1; m_cnt = (m_cnt + 1) % 16;
      end else if (diff == 3) begin
        exp_steps = 1; m_dir = 1'b0; m_cnt = (m_cnt + 15) % 16;
      end else if (diff == 2) begin
        exp_errs = 1;
      end
      st = t;
      exp_count = ~4'(m_cnt);
      check($sformatf("rand%0d_steps", op), step_total - s0 == exp_steps,
            step_total - s0, exp_steps);
      check($sformatf("rand%0d_errs", op), err_total - e0 == exp_errs,
            err_total - e0, exp_errs);
      check($sformatf("rand%0d_dir", op), bus.DIR == m_dir, bus.DIR, m_dir);
      check($sformatf("rand%0d_count", op), bus.COUNT == exp_count,
            bus.COUNT, exp_count);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
